serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 96 +++++++++
 tb/tb_serial_adder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are captured on start, added LSB-first one
// bit per clock through two half adders and a carry flop, then published with a done pulse.
module Half_adder (
   input  logic A,
   input  logic B,
   output logic CARRY,
   output logic SUM
);
   assign CARRY = A & B;
   assign SUM   = A ^ B;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a_sr, r_b_sr, r_r_sr, r_sum;
   logic             r_c, r_cout;
   logic [CW-1:0]    r_cnt;
   logic             w_c1, w_s1, w_c2, w_s, w_c_next;
   logic             w_accept, w_last;

   Half_adder u_ha1 (.A(r_a_sr[0]), .B(r_b_sr[0]), .CARRY(w_c1), .SUM(w_s1));
   Half_adder u_ha2 (.A(w_s1),      .B(r_c),       .CARRY(w_c2), .SUM(w_s));
   assign w_c_next = w_c1 | w_c2;

   // DONE accepts a new start just like IDLE, giving WIDTH+1 cycles per op.
   assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_last   = (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_SHIFT;
         S_SHIFT: if (w_last) w_next = S_DONE;
         S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sr <= '0;
         r_b_sr <= '0;
         r_r_sr <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_r_sr <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
         end else if (r_state == S_SHIFT) begin
            r_a_sr <= r_a_sr >> 1;
            r_b_sr <= r_b_sr >> 1;
            r_r_sr <= {w_s, r_r_sr[WIDTH-1:1]};
            r_c    <= w_c_next;
            // Counter saturates at the last bit index rather than wrapping.
            if (!w_last) r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
               r_sum  <= {w_s, r_r_sr[WIDTH-1:1]};
               r_cout <= w_c_next;
            end
         end
      end
   end

   assign busy      = (r_state == S_SHIFT);
   assign done      = (r_state == S_DONE);
   assign sum       = r_sum;
   assign carry_out = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst, start;
   logic [7:0] a, b;
   logic       busy, done, carry_out;
   logic [7:0] sum;
   int         n_checks = 0;
   int         n_fail   = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
   );

   always #5 clk = ~clk;

   // Pulses start for one edge, then watches 20 cycles. k counts negedges after the capture edge.
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                         output int nb, output int nd, output int dcyc);
      nb = 0; nd = 0; dcyc = -1;
      @(negedge clk); a = ia; b = ib; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (busy) nb++;
         if (done) begin nd++; if (dcyc < 0) dcyc = k; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, done, sum, carry_out} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc%0d: busy=%b done=%b sum=%h cout=%b, want all 0", k, busy, done, sum, carry_out);
         end
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_op: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      int nb, nd, dc;
      run_op(8'h03, 8'h05, nb, nd, dc);
      n_checks++;
      if (nb !== 8)  begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", nb); end
      n_checks++;
      if (nd !== 1)  begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", nd); end
      n_checks++;
      if (dc !== 9)  begin n_fail++; $display("FAIL basic_done_latency: got %0d want 9", dc); end
      n_checks++;
      if (sum !== 8'h08 || carry_out !== 1'b0) begin
         n_fail++; $display("FAIL basic_sum: got %h/%b want 08/0", sum, carry_out);
      end
   endtask

   task automatic test_ripple();
      int nb, nd, dc;
      run_op(8'hFF, 8'h01, nb, nd, dc);
      n_checks++;
      if (sum !== 8'h00 || carry_out !== 1'b1 || nd !== 1) begin
         n_fail++; $display("FAIL ripple_ff_01: got %h/%b done=%0d want 00/1 done=1", sum, carry_out, nd);
      end
      run_op(8'hFF, 8'hFF, nb, nd, dc);
      n_checks++;
      if (sum !== 8'hFE || carry_out !== 1'b1 || nd !== 1) begin
         n_fail++; $display("FAIL ripple_ff_ff: got %h/%b done=%0d want FE/1 done=1", sum, carry_out, nd);
      end
      run_op(8'hA5, 8'h5A, nb, nd, dc);
      n_checks++;
      if (sum !== 8'hFF || carry_out !== 1'b0) begin
         n_fail++; $display("FAIL no_carry_a5_5a: got %h/%b want FF/0", sum, carry_out);
      end
   endtask

   task automatic test_ignored_start();
      int nd, dc;
      nd = 0; dc = -1;
      @(negedge clk); a = 8'h10; b = 8'h20; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         if (done) begin nd++; if (dc < 0) dc = k; end
         if (k == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
         else begin start = 1'b0; end
         @(negedge clk);
      end
      n_checks++;
      if (nd !== 1 || dc !== 9) begin
         n_fail++; $display("FAIL ignored_start_done: count=%0d at=%0d want 1 at 9", nd, dc);
      end
      n_checks++;
      if (sum !== 8'h30 || carry_out !== 1'b0) begin
         n_fail++; $display("FAIL ignored_start_sum: got %h/%b want 30/0", sum, carry_out);
      end
   endtask

   task automatic test_back_to_back();
      int d1, d2, nd;
      logic hold_ok;
      d1 = -1; d2 = -1; nd = 0; hold_ok = 1'b1;
      @(negedge clk); a = 8'h7F; b = 8'h01; start = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 30; k++) begin
         if (done) begin
            nd++;
            if (d1 < 0) begin
               d1 = k;
               n_checks++;
               if (sum !== 8'h80 || carry_out !== 1'b0) begin
                  n_fail++; $display("FAIL b2b_first_sum: got %h/%b want 80/0", sum, carry_out);
               end
               a = 8'h80; b = 8'h80;
            end else if (d2 < 0) begin
               d2 = k;
               start = 1'b0;
            end
         end else if (d1 > 0 && d2 < 0 && sum !== 8'h80) begin
            hold_ok = 1'b0;
         end
         @(negedge clk);
      end
      n_checks++;
      if (d1 !== 9 || d2 !== 18 || nd !== 2) begin
         n_fail++; $display("FAIL b2b_done_spacing: d1=%0d d2=%0d count=%0d want 9 18 2", d1, d2, nd);
      end
      n_checks++;
      if (hold_ok !== 1'b1) begin
         n_fail++; $display("FAIL b2b_sum_hold: sum %h during 2nd op, want 80 held", sum);
      end
      n_checks++;
      if (sum !== 8'h00 || carry_out !== 1'b1) begin
         n_fail++; $display("FAIL b2b_second_sum: got %h/%b want 00/1", sum, carry_out);
      end
   endtask

   task automatic test_midop_reset();
      int nb, nd, dc;
      nd = 0;
      @(negedge clk); a = 8'h0F; b = 8'h0F; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k < 4; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0) begin
         n_fail++; $display("FAIL midop_reset: busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, carry_out);
      end
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done || busy) nd++;
         @(negedge clk);
      end
      n_checks++;
      if (nd !== 0) begin n_fail++; $display("FAIL midop_no_resume: %0d active cycles want 0", nd); end
      run_op(8'h0F, 8'h0F, nb, nd, dc);
      n_checks++;
      if (sum !== 8'h1E || carry_out !== 1'b0 || dc !== 9) begin
         n_fail++; $display("FAIL midop_restart: got %h/%b at %0d want 1E/0 at 9", sum, carry_out, dc);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      test_reset();
      test_basic();
      test_ripple();
      test_ignored_start();
      test_back_to_back();
      test_midop_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
